mvm_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `mvm` matrix-vector multiply engine among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and latches it. It then drives the engine's clear/start sequence, waits a fixed compute latency, and returns the truncated `WIDTH`-bit result vector to the granted requester over a valid/ready response channel. It sits between the layer controllers and the single `mvm` instance.

---
 rtl/mvm_arbiter_if.sv | 31 +++
 rtl/mvm_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mvm_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_arbiter_if.sv
// mvm_arbiter_if: requester-side bus shared between the layer controllers and
// mvm_arbiter.
//   req_valid/req_ready   : per-requester request handshake (ready is one-hot)
//   req_matrix/req_vector : per-requester operand slices, requester r in slice r
//   resp_valid/resp_ready : per-requester response handshake (valid is one-hot)
//   resp_data             : shared result vector, MATRIX_ROWS elements of WIDTH
// Modports: master = requester side, slave = arbiter side.
interface mvm_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int MATRIX_ROWS = 3,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8
);
  logic [NUM_REQ-1:0]                               req_valid;
  logic [NUM_REQ-1:0]                               req_ready;
  logic [NUM_REQ*MATRIX_ROWS*SHARED_DIM*WIDTH-1:0]  req_matrix;
  logic [NUM_REQ*SHARED_DIM*WIDTH-1:0]              req_vector;
  logic [NUM_REQ-1:0]                               resp_valid;
  logic [NUM_REQ-1:0]                               resp_ready;
  logic [MATRIX_ROWS*WIDTH-1:0]                     resp_data;

  modport master (
    output req_valid, req_matrix, req_vector, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_matrix, req_vector, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mvm_arbiter.sv
// mvm_arbiter: shares one mvm matrix-vector engine among NUM_REQ requesters.
// Accepts one operand pair at a time, latches it, pulses the engine clear and
// start, waits MVM_LATENCY cycles, then returns the engine result to the
// granted requester over a valid/ready response channel.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus (slave modport)   : requester handshakes, operands and shared result
//   busy                  : high whenever the sequencer is not idle
//   mvm_reset, mvm_start  : engine clear (also held during reset) and start pulse
//   mvm_matrix/mvm_vector : latched operands, stable from CLEAR to next grant
//   mvm_result            : engine output, captured after MVM_LATENCY cycles
//
// Build option: define MVM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); default is round-robin.
module mvm_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MATRIX_ROWS = 3,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8,
  parameter int MVM_LATENCY = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  mvm_arbiter_if.slave                            bus,
  output logic                                    busy,
  output logic                                    mvm_reset,
  output logic                                    mvm_start,
  output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] mvm_matrix,
  output logic [SHARED_DIM*WIDTH-1:0]             mvm_vector,
  input  logic [MATRIX_ROWS*WIDTH-1:0]            mvm_result
);
  localparam int MAT_W = MATRIX_ROWS * SHARED_DIM * WIDTH;
  localparam int VEC_W = SHARED_DIM * WIDTH;
  localparam int RES_W = MATRIX_ROWS * WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MVM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               clear_reg;
  logic               start_reg;
  logic               busy_reg;
  logic [NUM_REQ-1:0] resp_valid_reg;
  logic [RES_W-1:0]   resp_data_reg;
  logic [MAT_W-1:0]   matrix_reg;
  logic [VEC_W-1:0]   vector_reg;

  logic [IDX_W-1:0]   search_base;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               resp_done;

`ifdef MVM_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr_reg;
  assign search_base = rr_ptr_reg;
`endif

  // First asserted request at or after search_base, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(search_base) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign win_onehot[gi]   = win_found && (win_idx == IDX_W'(gi));
    assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
  end

  // Grant is only offered in IDLE and never while reset is asserted, so
  // req_ready reads zero during reset even if requests are already pending.
  assign bus.req_ready = (state_reg == IDLE && reset_n) ? win_onehot : '0;

  // Only the owner's ready bit completes the response.
  assign resp_done = (state_reg == RESP) && |(bus.resp_ready & grant_onehot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      cnt_reg        <= '0;
      clear_reg      <= 1'b0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      matrix_reg     <= '0;
      vector_reg     <= '0;
`ifndef MVM_ARB_FIXED_PRIO_EN
      rr_ptr_reg     <= '0;
`endif
    end else begin
      clear_reg <= 1'b0;
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            matrix_reg <= bus.req_matrix[int'(win_idx)*MAT_W +: MAT_W];
            vector_reg <= bus.req_vector[int'(win_idx)*VEC_W +: VEC_W];
            grant_reg  <= win_idx;
`ifndef MVM_ARB_FIXED_PRIO_EN
            rr_ptr_reg <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
            clear_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= CLEAR;
          end
        end
        CLEAR: begin
          start_reg <= 1'b1;
          state_reg <= START;
        end
        START: begin
          cnt_reg   <= CNT_W'(MVM_LATENCY);
          state_reg <= WAIT;
        end
        WAIT: begin
          // The last WAIT cycle is MVM_LATENCY cycles after the start cycle,
          // which is when the engine result becomes valid.
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            resp_data_reg  <= mvm_result;
            resp_valid_reg <= grant_onehot;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (resp_done) begin
            resp_valid_reg <= '0;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;
  assign busy           = busy_reg;
  assign mvm_reset      = ~reset_n | clear_reg;
  assign mvm_start      = start_reg;
  assign mvm_matrix     = matrix_reg;
  assign mvm_vector     = vector_reg;
endmodule

// File: tb/tb_mvm_arbiter.sv
// tb_mvm_arbiter: drives mvm_arbiter with directed and random requests and
// models the mvm engine (dot products modulo 2^WIDTH after MVM_LATENCY cycles).
module tb_mvm_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int MATRIX_ROWS = 3;
  localparam int SHARED_DIM  = 3;
  localparam int WIDTH       = 8;
  localparam int MVM_LATENCY = 4;
  localparam int MAT_W = MATRIX_ROWS * SHARED_DIM * WIDTH;
  localparam int VEC_W = SHARED_DIM * WIDTH;
  localparam int RES_W = MATRIX_ROWS * WIDTH;
`ifdef MVM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             busy;
  logic             mvm_reset;
  logic             mvm_start;
  logic [MAT_W-1:0] mvm_matrix;
  logic [VEC_W-1:0] mvm_vector;
  logic [RES_W-1:0] mvm_result;

  mvm_arbiter_if #(.NUM_REQ(NUM_REQ), .MATRIX_ROWS(MATRIX_ROWS),
                   .SHARED_DIM(SHARED_DIM), .WIDTH(WIDTH)) bus ();

  mvm_arbiter #(.NUM_REQ(NUM_REQ), .MATRIX_ROWS(MATRIX_ROWS), .SHARED_DIM(SHARED_DIM),
                .WIDTH(WIDTH), .MVM_LATENCY(MVM_LATENCY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .mvm_reset  (mvm_reset),
    .mvm_start  (mvm_start),
    .mvm_matrix (mvm_matrix),
    .mvm_vector (mvm_vector),
    .mvm_result (mvm_result)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int model_ptr = 0;
  logic [MAT_W-1:0] op_m [NUM_REQ];
  logic [VEC_W-1:0] op_v [NUM_REQ];

  function automatic logic [RES_W-1:0] mvm_ref(input logic [MAT_W-1:0] m, input logic [VEC_W-1:0] v);
    logic [RES_W-1:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < MATRIX_ROWS; i++) begin
      acc = 0;
      for (int j = 0; j < SHARED_DIM; j++)
        acc += int'(m[(i*SHARED_DIM+j)*WIDTH +: WIDTH]) * int'(v[j*WIDTH +: WIDTH]);
      r[i*WIDTH +: WIDTH] = WIDTH'(acc);
    end
    return r;
  endfunction

  function automatic int model_winner(input logic [NUM_REQ-1:0] valid, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (ptr + k) % NUM_REQ;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // Engine model: garbage until MVM_LATENCY cycles after the start cycle.
  int eng_cnt = 0;
  logic [RES_W-1:0] eng_job;
  always @(posedge clk) begin
    if (mvm_reset) begin
      eng_cnt    <= 0;
      mvm_result <= RES_W'($urandom);
    end else if (mvm_start) begin
      eng_job    <= mvm_ref(mvm_matrix, mvm_vector);
      mvm_result <= RES_W'($urandom);
      eng_cnt    <= MVM_LATENCY - 1;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) mvm_result <= eng_job;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops(input int r);
    op_m[r] = MAT_W'({$urandom, $urandom, $urandom});
    op_v[r] = VEC_W'($urandom);
  endtask

  task automatic drive_ops();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_matrix[r*MAT_W +: MAT_W] = op_m[r];
      bus.req_vector[r*VEC_W +: VEC_W] = op_v[r];
    end
  endtask

  // One complete job: acceptance, clear/start sequencing, latency, response.
  task automatic serve_one(input bit drop_winner, input logic [NUM_REQ-1:0] raise_mask,
                           input int hold, output int granted, output int waited,
                           output logic [RES_W-1:0] got);
    int g;
    logic [NUM_REQ-1:0] g1h;
    logic [MAT_W-1:0]   em;
    logic [VEC_W-1:0]   ev;
    logic [RES_W-1:0]   edata;
    granted = -1;
    waited  = 0;
    got     = '0;
    #1;
    while (bus.req_ready == '0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (bus.req_ready == '0) begin
      chk("accept", |bus.req_ready, 1'b1);
      return;
    end
    g = model_winner(bus.req_valid, model_ptr);
    g1h = '0;
    if (g >= 0) g1h[g] = 1'b1;
    chk("grant", bus.req_ready, g1h);
    for (int r = 0; r < NUM_REQ; r++) if (bus.req_ready[r]) granted = r;
    g1h = '0;
    g1h[granted] = 1'b1;
    em = op_m[granted];
    ev = op_v[granted];
    edata = mvm_ref(em, ev);
    @(posedge clk); #1;
    rand_ops(granted);
    drive_ops();
    if (drop_winner) bus.req_valid[granted] = 1'b0;
    bus.req_valid = bus.req_valid | raise_mask;
    bus.resp_ready = (hold > 0) ? ~g1h : '1;
    @(negedge clk);
    chk("clear_rst", mvm_reset, 1'b1);
    chk("clear_start", mvm_start, 1'b0);
    chk("busy_rise", busy, 1'b1);
    chk("ready_low", bus.req_ready, '0);
    chk("op_matrix", mvm_matrix, em);
    chk("op_vector", mvm_vector, ev);
    @(negedge clk);
    chk("start_rst", mvm_reset, 1'b0);
    chk("start_pulse", mvm_start, 1'b1);
    chk("op_matrix2", mvm_matrix, em);
    for (int k = 0; k < MVM_LATENCY; k++) begin
      @(negedge clk);
      chk("wait_start", mvm_start, 1'b0);
      chk("wait_rst", mvm_reset, 1'b0);
      chk("wait_rv", bus.resp_valid, '0);
    end
    @(negedge clk);
    chk("resp_valid", bus.resp_valid, g1h);
    chk("resp_data", bus.resp_data, edata);
    got = bus.resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rv", bus.resp_valid, g1h);
      chk("hold_rd", bus.resp_data, edata);
      chk("hold_ready", bus.req_ready, '0);
      chk("hold_busy", busy, 1'b1);
    end
    bus.resp_ready = '1;
    @(negedge clk);
    chk("resp_clr", bus.resp_valid, '0);
    chk("busy_fall", busy, 1'b0);
    model_ptr = FIXED ? 0 : (granted + 1) % NUM_REQ;
    $display("[TB] job req=%0d data=%0h waited=%0d hold=%0d", granted, got, waited, hold);
  endtask

  initial begin
    int g;
    int w;
    logic [RES_W-1:0] d;
    int order [4];
    int exp_order;

    bus.req_valid  = '0;
    bus.resp_ready = '1;
    for (int r = 0; r < NUM_REQ; r++) rand_ops(r);
    drive_ops();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_resp_valid", bus.resp_valid, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mvm_start, 1'b0);
    chk("rst_mvm_reset", mvm_reset, 1'b1);
    chk("rst_resp_data", bus.resp_data, '0);
    chk("rst_matrix", mvm_matrix, '0);
    chk("rst_vector", mvm_vector, '0);
    reset_n = 1'b1;
    #1;
    chk("rel_mvm_reset", mvm_reset, 1'b0);

    // Single request with known operands.
    op_m[0] = 72'h010203040506070809;
    op_v[0] = 24'h010203;
    drive_ops();
    bus.req_valid = 2'b01;
    serve_one(1'b1, '0, 0, g, w, d);
    chk("t1_grant", g, 0);
    chk("t1_data", d, 24'h0E2032);

    // Per-element wrap: results pass through modulo 2^WIDTH.
    op_m[1] = 72'h131415161718191A1B;
    op_v[1] = 24'h070809;
    drive_ops();
    bus.req_valid = 2'b10;
    serve_one(1'b1, '0, 0, g, w, d);
    chk("t2_grant", g, 1);

    // Backpressure on requester 1 while requester 0 waits.
    rand_ops(0);
    rand_ops(1);
    drive_ops();
    bus.req_valid = 2'b10;
    serve_one(1'b1, 2'b01, 10, g, w, d);
    chk("bp_grant", g, 1);
    serve_one(1'b1, '0, 0, g, w, d);
    chk("bp_next_grant", g, 0);
    chk("bp_next_lat", w, 0);

    // Random traffic.
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NUM_REQ; r++) rand_ops(r);
      drive_ops();
      bus.req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      serve_one(1'($urandom_range(0, 1)), '0, $urandom_range(0, 3), g, w, d);
    end
    bus.req_valid = '0;

    // Both requesters valid from reset.
    reset_n = 1'b0;
    model_ptr = 0;
    for (int r = 0; r < NUM_REQ; r++) rand_ops(r);
    drive_ops();
    bus.req_valid = '1;
    @(negedge clk);
    #1;
    chk("rst_ready_gated", bus.req_ready, '0);
    chk("rst_busy2", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      serve_one(1'b0, '0, 0, g, w, d);
      order[j] = g;
      if (j > 0) chk("rr_back2back", w, 0);
    end
    for (int j = 0; j < 4; j++) begin
      exp_order = FIXED ? 0 : (j % 2);
      chk("rr_order", order[j], exp_order);
    end

    // Reset two cycles after START.
    bus.req_valid = '0;
    rand_ops(0);
    drive_ops();
    @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    chk("mr_ready", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_start", mvm_start, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_rv", bus.resp_valid, '0);
    chk("mr_start0", mvm_start, 1'b0);
    chk("mr_mvm_reset", mvm_reset, 1'b1);
    chk("mr_rd", bus.resp_data, '0);
    chk("mr_matrix", mvm_matrix, '0);
    chk("mr_vector", mvm_vector, '0);
    chk("mr_ready0", bus.req_ready, '0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_hold_rv", bus.resp_valid, '0);
    end
    reset_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    chk("mr_post_rv", bus.resp_valid, '0);
    chk("mr_post_busy", busy, 1'b0);
    rand_ops(1);
    drive_ops();
    bus.req_valid = 2'b10;
    serve_one(1'b1, '0, 0, g, w, d);
    chk("mr_recover_grant", g, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
